// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-requester SDRAM port arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    // A read ID is simply the index of the requester that issued it.
    localparam int ID_W       = 1;
    localparam int DEF_ADDR_W = 25;
    localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/sdram_arb_id_fifo.sv
// In-order FIFO of read IDs; head tells which requester owns the next return.
module sdram_arb_id_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_push,
    input  logic [ID_W-1:0] i_push_id,
    input  logic            i_pop,
    output logic            o_full,
    output logic            o_empty,
    output logic [ID_W-1:0] o_head
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [ID_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_push_id;
                r_wr_ptr                <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin, parking Avalon-MM arbiter for two masters onto one SDRAM port.
// Valid/ready: a command transfers in the cycle s_read|s_write is high and s_waitrequest is low.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BE_W      = DATA_W / 8,
    parameter int MAX_OUTST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,
    output logic              rdv_error,
    output state_t            dbg_state
);

    state_t          r_state;
    logic            r_last;
    logic            r_rdv_error;
    logic            w_req0;
    logic            w_req1;
    logic            w_own1;
    logic            w_owned;
    logic            w_req_owner;
    logic            w_req_other;
    logic            w_sel_read;
    logic            w_sel_write;
    logic            w_accept;
    logic            w_full;
    logic            w_empty;
    logic [ID_W-1:0] w_head;

    assign w_req0      = m0_read || m0_write;
    assign w_req1      = m1_read || m1_write;
    assign w_own1      = (r_state == ST_OWN1);
    assign w_owned     = (r_state == ST_OWN0) || w_own1;
    assign w_req_owner = w_own1 ? w_req1 : w_req0;
    assign w_req_other = w_own1 ? w_req0 : w_req1;
    assign w_sel_read  = w_own1 ? m1_read : m0_read;
    assign w_sel_write = w_own1 ? m1_write : m0_write;

    assign s_address    = w_own1 ? m1_address : m0_address;
    assign s_writedata  = w_own1 ? m1_writedata : m0_writedata;
    assign s_byteenable = w_own1 ? m1_byteenable : m0_byteenable;
    assign s_read       = w_owned && w_sel_read && !w_full;
    assign s_write      = w_owned && w_sel_write;
    assign w_accept     = (s_read || s_write) && !s_waitrequest;

    assign m0_waitrequest = (r_state == ST_OWN0) ? (s_waitrequest || (m0_read && w_full)) : 1'b1;
    assign m1_waitrequest = w_own1 ? (s_waitrequest || (m1_read && w_full)) : 1'b1;

    // Read data is broadcast; only the valid strobe is steered by the head ID.
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = s_readdatavalid && !w_empty && (w_head == 1'b0);
    assign m1_readdatavalid = s_readdatavalid && !w_empty && (w_head == 1'b1);

    assign rdv_error = r_rdv_error;
    assign dbg_state = r_state;

    sdram_arb_id_fifo #(
        .DEPTH(MAX_OUTST)
    ) u_id_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_push   (w_accept && s_read),
        .i_push_id(w_own1),
        .i_pop    (s_readdatavalid),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_head   (w_head)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_rdv_error <= 1'b0;
        end else begin
            if (s_readdatavalid && w_empty) begin
                r_rdv_error <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_req0 && w_req1) begin
                        r_state <= r_last ? ST_OWN0 : ST_OWN1;
                    end else if (w_req0) begin
                        r_state <= ST_OWN0;
                    end else if (w_req1) begin
                        r_state <= ST_OWN1;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    // A stalled owner command keeps the grant until it is accepted.
                    if (w_accept) begin
                        r_last <= w_own1;
                        if (w_req_other) begin
                            r_state <= w_own1 ? ST_OWN0 : ST_OWN1;
                        end
                    end else if (!w_req_owner) begin
                        if (w_req_other) begin
                            r_state <= w_own1 ? ST_OWN0 : ST_OWN1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed scenarios for sdram_port_arbiter with a {id, data} read-return scoreboard.
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [24:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata, s_writedata;
    logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid;
    logic        rdv_error;
    state_t      dbg_state;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    sdram_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .rdv_error(rdv_error),
        .dbg_state(dbg_state)
    );

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = 2'b11;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = 2'b11;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
        exp_q.delete();
        next_cyc();
        next_cyc();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({m0_waitrequest, m1_waitrequest, s_read, s_write, rdv_error} !== 5'b11000)
            $display("FAIL reset_outputs: got %b expected 11000", {m0_waitrequest, m1_waitrequest, s_read, s_write, rdv_error});
        else n_pass++;
        n_checks++;
        if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
        else n_pass++;
        next_cyc();
    endtask

    task automatic test_single_read();
        logic [16:0] e;
        do_reset();
        m0_read = 1'b1; m0_address = 25'h0000010;
        @(negedge clk);
        n_checks++;
        if (s_read !== 1'b0) $display("FAIL read_latency_idle: s_read got %b expected 0", s_read);
        else n_pass++;
        next_cyc();
        @(negedge clk);
        n_checks++;
        if ({s_read, m0_waitrequest, s_address} !== {1'b1, 1'b0, 25'h0000010})
            $display("FAIL read_issue: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=0000010", s_read, m0_waitrequest, s_address);
        else n_pass++;
        exp_q.push_back({1'b0, 16'hBEEF});
        next_cyc();
        m0_read = 1'b0;
        next_cyc();
        next_cyc();
        s_readdatavalid = 1'b1; s_readdata = 16'hBEEF;
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if ({m1_readdatavalid, m0_readdatavalid, m0_readdata} !== {e[16], ~e[16], e[15:0]})
            $display("FAIL single_return: got v1=%b v0=%b d0=%h expected v1=%b v0=%b d0=%h",
                     m1_readdatavalid, m0_readdatavalid, m0_readdata, e[16], ~e[16], e[15:0]);
        else n_pass++;
        next_cyc();
        s_readdatavalid = 1'b0;
    endtask

    task automatic test_rr_writes();
        logic [15:0] wq[$];
        logic [15:0] w;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wq.push_back(16'h1111);
            wq.push_back(16'h2222);
        end
        m0_write = 1'b1; m0_writedata = 16'h1111; m0_address = 25'h100;
        m1_write = 1'b1; m1_writedata = 16'h2222; m1_address = 25'h200;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (s_write && !s_waitrequest) begin
                n_checks++;
                if (wq.size() == 0) $display("FAIL rr_extra_accept: got data %h expected none", s_writedata);
                else begin
                    w = wq.pop_front();
                    if (s_writedata !== w) $display("FAIL rr_order: got %h expected %h", s_writedata, w);
                    else n_pass++;
                end
            end
            next_cyc();
        end
        n_checks++;
        if (wq.size() != 0) $display("FAIL rr_accept_count: got %0d left expected 0", wq.size());
        else n_pass++;
        m0_write = 1'b0; m1_write = 1'b0;
        next_cyc();
    endtask

    task automatic test_hold();
        do_reset();
        s_waitrequest = 1'b1;
        m1_write = 1'b1; m1_address = 25'h0000123; m1_writedata = 16'h3333;
        next_cyc();
        m0_read = 1'b1; m0_address = 25'h0000055;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({dbg_state, s_address, m0_waitrequest, m1_waitrequest} !== {ST_OWN1, 25'h0000123, 1'b1, 1'b1})
                $display("FAIL hold_cycle%0d: got st=%0d addr=%h w0=%b w1=%b expected st=%0d addr=0000123 w0=1 w1=1",
                         i, dbg_state, s_address, m0_waitrequest, m1_waitrequest, ST_OWN1);
            else n_pass++;
            next_cyc();
        end
        s_waitrequest = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_write, m1_waitrequest, s_writedata} !== {1'b1, 1'b0, 16'h3333})
            $display("FAIL hold_accept: got wr=%b w1=%b d=%h expected 1 0 3333", s_write, m1_waitrequest, s_writedata);
        else n_pass++;
        next_cyc();
        m1_write = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dbg_state, s_read, s_address} !== {ST_OWN0, 1'b1, 25'h0000055})
            $display("FAIL hold_handover: got st=%0d rd=%b addr=%h expected st=%0d rd=1 addr=0000055",
                     dbg_state, s_read, s_address, ST_OWN0);
        else n_pass++;
        next_cyc();
        m0_read = 1'b0;
        next_cyc();
    endtask

    task automatic test_fifo_full();
        int          acc;
        logic [16:0] e;
        do_reset();
        acc = 0;
        m0_read = 1'b1; m0_address = 25'h200;
        next_cyc();
        for (int i = 0; i < 4; i++) begin
            m0_address = 25'h200 + 25'(i);
            @(negedge clk);
            if (s_read && !m0_waitrequest) begin
                acc++;
                exp_q.push_back({1'b0, 16'h4000 + 16'(i)});
            end
            next_cyc();
        end
        n_checks++;
        if (acc != 4) $display("FAIL full_accepts: got %0d expected 4", acc);
        else n_pass++;
        m0_address = 25'h204;
        @(negedge clk);
        n_checks++;
        if ({s_read, m0_waitrequest} !== 2'b01) $display("FAIL full_block: got rd=%b w0=%b expected rd=0 w0=1", s_read, m0_waitrequest);
        else n_pass++;
        next_cyc();
        m0_read = 1'b0;
        m1_write = 1'b1; m1_address = 25'h300; m1_writedata = 16'h5555;
        next_cyc();
        @(negedge clk);
        n_checks++;
        if ({s_write, m1_waitrequest, s_writedata} !== {1'b1, 1'b0, 16'h5555})
            $display("FAIL full_write_pass: got wr=%b w1=%b d=%h expected 1 0 5555", s_write, m1_waitrequest, s_writedata);
        else n_pass++;
        next_cyc();
        m1_write = 1'b0;
        m0_read = 1'b1; m0_address = 25'h204;
        next_cyc();
        s_readdatavalid = 1'b1; s_readdata = 16'h4000;
        @(negedge clk);
        n_checks++;
        if ({s_read, m0_waitrequest} !== 2'b01) $display("FAIL full_still_block: got rd=%b w0=%b expected rd=0 w0=1", s_read, m0_waitrequest);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if ({m1_readdatavalid, m0_readdatavalid, m0_readdata} !== {e[16], ~e[16], e[15:0]})
            $display("FAIL full_return0: got v1=%b v0=%b d=%h expected v1=%b v0=%b d=%h",
                     m1_readdatavalid, m0_readdatavalid, m0_readdata, e[16], ~e[16], e[15:0]);
        else n_pass++;
        next_cyc();
        // Fifth read is accepted in the same cycle as the next return.
        s_readdata = 16'h4001;
        @(negedge clk);
        n_checks++;
        if ({s_read, m0_waitrequest} !== 2'b10) $display("FAIL full_unblock: got rd=%b w0=%b expected rd=1 w0=0", s_read, m0_waitrequest);
        else n_pass++;
        exp_q.push_back({1'b0, 16'h4004});
        e = exp_q.pop_front();
        n_checks++;
        if ({m1_readdatavalid, m0_readdatavalid, m0_readdata} !== {e[16], ~e[16], e[15:0]})
            $display("FAIL full_push_pop: got v1=%b v0=%b d=%h expected v1=%b v0=%b d=%h",
                     m1_readdatavalid, m0_readdatavalid, m0_readdata, e[16], ~e[16], e[15:0]);
        else n_pass++;
        next_cyc();
        m0_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_readdata = 16'h4002 + 16'(i);
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL full_drain%0d: got empty queue expected entry", i);
            else begin
                e = exp_q.pop_front();
                if ({m1_readdatavalid, m0_readdatavalid, m0_readdata} !== {e[16], ~e[16], e[15:0]})
                    $display("FAIL full_drain%0d: got v1=%b v0=%b d=%h expected v1=%b v0=%b d=%h",
                             i, m1_readdatavalid, m0_readdatavalid, m0_readdata, e[16], ~e[16], e[15:0]);
                else n_pass++;
            end
            next_cyc();
        end
        s_readdatavalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rdv_error !== 1'b0) $display("FAIL full_no_error: got %b expected 0", rdv_error);
        else n_pass++;
        next_cyc();
    endtask

    task automatic test_interleave();
        logic [16:0] e;
        logic [15:0] got_d;
        do_reset();
        m0_read = 1'b1; m0_address = 25'h10A;
        next_cyc();
        m1_read = 1'b1; m1_address = 25'h20B;
        @(negedge clk);
        n_checks++;
        if ({s_read, m0_waitrequest, s_address} !== {1'b1, 1'b0, 25'h10A})
            $display("FAIL il_issue0: got rd=%b w0=%b addr=%h expected 1 0 000010a", s_read, m0_waitrequest, s_address);
        else n_pass++;
        exp_q.push_back({1'b0, 16'h000A});
        next_cyc();
        m0_address = 25'h10C;
        @(negedge clk);
        n_checks++;
        if ({s_read, m1_waitrequest, s_address} !== {1'b1, 1'b0, 25'h20B})
            $display("FAIL il_issue1: got rd=%b w1=%b addr=%h expected 1 0 000020b", s_read, m1_waitrequest, s_address);
        else n_pass++;
        exp_q.push_back({1'b1, 16'h000B});
        next_cyc();
        m1_read = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_read, m0_waitrequest, s_address} !== {1'b1, 1'b0, 25'h10C})
            $display("FAIL il_issue2: got rd=%b w0=%b addr=%h expected 1 0 000010c", s_read, m0_waitrequest, s_address);
        else n_pass++;
        exp_q.push_back({1'b0, 16'h000C});
        next_cyc();
        m0_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_readdatavalid = 1'b1;
            s_readdata = 16'h000A + 16'(i);
            @(negedge clk);
            e = exp_q.pop_front();
            got_d = e[16] ? m1_readdata : m0_readdata;
            n_checks++;
            if ({m1_readdatavalid, m0_readdatavalid, got_d} !== {e[16], ~e[16], e[15:0]})
                $display("FAIL il_return%0d: got v1=%b v0=%b d=%h expected v1=%b v0=%b d=%h",
                         i, m1_readdatavalid, m0_readdatavalid, got_d, e[16], ~e[16], e[15:0]);
            else n_pass++;
            next_cyc();
        end
        s_readdatavalid = 1'b0;
        next_cyc();
    endtask

    task automatic test_rdv_error();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (rdv_error !== 1'b0) $display("FAIL err_initial: got %b expected 0", rdv_error);
        else n_pass++;
        next_cyc();
        s_readdatavalid = 1'b1; s_readdata = 16'hDEAD;
        @(negedge clk);
        n_checks++;
        if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00)
            $display("FAIL err_no_valid: got v0=%b v1=%b expected 0 0", m0_readdatavalid, m1_readdatavalid);
        else n_pass++;
        next_cyc();
        s_readdatavalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (rdv_error !== 1'b1) $display("FAIL err_sticky%0d: got %b expected 1", i, rdv_error);
            else n_pass++;
            next_cyc();
        end
        reset_n = 1'b0;
        next_cyc();
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rdv_error !== 1'b0) $display("FAIL err_clear: got %b expected 0", rdv_error);
        else n_pass++;
        next_cyc();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_writes();
        test_hold();
        test_fifo_full();
        test_interleave();
        test_rdv_error();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-requester Avalon-MM arbiter sharing the single SDRAM controller slave port inside the system.
- Requester 0 is the VGA pixel-buffer read path. Requester 1 is the HPS/drawing-engine path.
- Round-robin grant with parking. Pipelined reads are tracked in an in-order ID FIFO so that each readdatavalid returns to the requester that issued it.
- Sits between the two masters and the SDRAM controller; single clock domain.

Parameters:
- ADDR_W, 25, word address width (32M x 16-bit SDRAM).
- DATA_W, 16, data width.
- BE_W, 2, byteenable width (DATA_W/8).
- MAX_OUTST, 4, maximum outstanding reads (ID FIFO depth, power of 2, >=2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- m0_address, m1_address  in  ADDR_W  requester word address.
- m0_read, m1_read  in  1  read request.
- m0_write, m1_write  in  1  write request (read and write are never asserted together).
- m0_writedata, m1_writedata  in  DATA_W  write data.
- m0_byteenable, m1_byteenable  in  BE_W  byte lanes.
- m0_waitrequest, m1_waitrequest  out  1  stall to requester.
- m0_readdata, m1_readdata  out  DATA_W  returned data.
- m0_readdatavalid, m1_readdatavalid  out  1  return strobe.
- s_address  out  ADDR_W  to SDRAM controller.
- s_read, s_write  out  1  command strobes.
- s_writedata  out  DATA_W.
- s_byteenable  out  BE_W.
- s_waitrequest  in  1  controller stall.
- s_readdata  in  DATA_W.
- s_readdatavalid  in  1.
- rdv_error  out  1  sticky: readdatavalid received with ID FIFO empty.

Behaviour:
- Grant FSM has three states: IDLE, OWN0, OWN1. Reset enters IDLE.
  - Reset values: fifo empty, last_served=1, rdv_error=0.
- IDLE:
  - s_read=s_write=0. Both m*_waitrequest=1.
  - Next state: OWN(n) if only n requests. If both request: OWN(!last_served).
  - Arbitration latency is 1 cycle.
- OWN(n), command forwarding:
  - s_address, s_writedata, s_byteenable, s_read and s_write are driven combinationally from requester n.
  - Exception: s_read is forced 0 when the fifo is full.
  - mn_waitrequest = s_waitrequest OR (mn_read AND fifo_full).
  - The other requester's waitrequest is held at 1.
- Accept = (s_read OR s_write) AND NOT s_waitrequest.
- On accept in OWN(n):
  - last_served <= n.
  - Next state is OWN(other) if the other requester is requesting; otherwise stay in OWN(n) (parked). This gives back-to-back single-requester throughput of 1 per cycle.
- In OWN(n) with mn idle (no read/write):
  - Move to OWN(other) if the other requests; else go to IDLE.
  - No command is issued during the switch cycle.
- Grant never changes while the owner holds a stalled command (request asserted and not accepted). This satisfies Avalon's command-hold rule.
- ID FIFO:
  - Each accepted read pushes n.
  - Each s_readdatavalid pops the head ID h.
  - mh_readdatavalid = s_readdatavalid. Both m*_readdata = s_readdata (unconditionally broadcast).
  - Simultaneous push and pop in one cycle is legal: count is unchanged and order is preserved.
- Full/empty boundaries:
  - Fifo full: reads are blocked, writes still pass.
  - s_readdatavalid while empty: no m*_readdatavalid is asserted, rdv_error <= 1 (cleared only by reset), and the pointers are not moved.
- Fifo pointers are log2(MAX_OUTST)+1 bits wide, using natural wrap and an MSB full/empty compare.
- Writes have no response and do not touch the fifo.
- Reset mid-operation:
  - All state is cleared on the next clk edge and the outstanding read IDs are discarded.
  - The SDRAM controller is reset by the same system reset, so no stale returns follow.

Decomposition:
- Shared package sdram_arb_pkg holds:
  - the state enum (ST_IDLE, ST_OWN0, ST_OWN1);
  - the ID width constant;
  - the default ADDR_W/DATA_W constants.
- One sub-module, sdram_arb_id_fifo: a 1-bit-wide, MAX_OUTST-deep synchronous FIFO with push, pop, full, empty and head outputs.
- Grant FSM and muxing live in the top.

Test Plan:
1. Reset, then m0_read at addr 0x0000010 with s_waitrequest=0 and s_readdatavalid 3 cycles later carrying 0xBEEF:
   - s_read is seen 1 cycle after request;
   - m0_readdatavalid=1 with 0xBEEF;
   - m1_readdatavalid stays 0.
2. Both masters issue a continuous write stream (m0 0x1111, m1 0x2222):
   - s_writedata alternates 0x1111/0x2222 per accept;
   - first grant goes to m0 (last_served=1 at reset).
3. m1_write is held while s_waitrequest=1 for 5 cycles, and m0 requests meanwhile:
   - grant stays OWN1;
   - s_address is stable for all 5 cycles;
   - m0 is granted the cycle after accept.
4. m0 issues 5 reads with the controller returning none (MAX_OUTST=4):
   - 4 accepted;
   - the 5th has m0_waitrequest=1 and s_read=0;
   - a m1 write is still accepted;
   - after one s_readdatavalid, the 5th read is accepted.
5. Interleaved reads m0, m1, m0, then returns 0xA, 0xB, 0xC:
   - routed m0=0xA, m1=0xB, m0=0xC, in order.
6. s_readdatavalid pulse with the fifo empty:
   - rdv_error=1 and stays 1;
   - no m*_readdatavalid is asserted;
   - reset_n=0 for 1 cycle clears rdv_error to 0.
